// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern generator: mode encoding,
// config handshake states and the triangle-wave shaping function.
package led_pkg;

   localparam int MODE_W    = 2;
   localparam int TRI_MAX_W = 32;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF     = 2'd0,
      MODE_SWEEP   = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_CHASE   = 2'd3
   } mode_e;

   typedef enum logic {
      CFG_IDLE    = 1'b0,
      CFG_PENDING = 1'b1
   } cfg_state_e;

   // Folds a (bits+1)-wide phase into a rising-then-falling ramp of width bits.
   function automatic logic [TRI_MAX_W-1:0] tri_wave(input logic [TRI_MAX_W-1:0] x,
                                                     input int unsigned bits);
      logic [TRI_MAX_W-1:0] mask;
      mask = (TRI_MAX_W'(1) << bits) - TRI_MAX_W'(1);
      return x[bits[4:0]] ? (~x & mask) : (x & mask);
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One LED channel: holds its duty value, reloaded on the shared period strobe,
// and a registered compare against the shared PWM counter.
module pwm_channel #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load_i,
   input  logic [PWM_BITS-1:0] duty_i,
   input  logic [PWM_BITS-1:0] pwm_ctr_i,
   output logic                led_o
);

   logic [PWM_BITS-1:0] duty_q;
   logic [PWM_BITS-1:0] duty_d;
   logic                led_q;
   logic                led_d;

   always_comb begin
      duty_d = load_i ? duty_i : duty_q;
      led_d  = (duty_q > pwm_ctr_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         duty_q <= '0;
         led_q  <= 1'b0;
      end else begin
         duty_q <= duty_d;
         led_q  <= led_d;
      end
   end

   assign led_o = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared PWM/phase counters, a runtime
// config handshake applied on period boundaries, and per-channel duty selection.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int NUM_LEDS      = 8,
   parameter int PWM_BITS      = 8,
   parameter int DIV_BITS      = 16,
   parameter int DEFAULT_SPEED = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [MODE_W-1:0]   cfg_mode_i,
   input  logic [DIV_BITS-1:0] cfg_speed_i,
   input  logic                cfg_valid_i,
   output logic                cfg_ready_o,
   output logic [NUM_LEDS-1:0] led_o,
   output logic                frame_o
);

   localparam int PH_W   = PWM_BITS + 1;
   localparam int OFFSET = (1 << PH_W) / NUM_LEDS;
   localparam int IDX_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   logic [PWM_BITS-1:0] pwm_ctr_q,   pwm_ctr_d;
   logic [DIV_BITS-1:0] div_ctr_q,   div_ctr_d;
   logic [PH_W-1:0]     phase_q,     phase_d;
   logic [IDX_W-1:0]    chase_idx_q, chase_idx_d;
   mode_e               mode_q,      mode_d;
   logic [DIV_BITS-1:0] speed_q,     speed_d;
   mode_e               pend_mode_q, pend_mode_d;
   logic [DIV_BITS-1:0] pend_speed_q, pend_speed_d;
   cfg_state_e          cfg_state_q, cfg_state_d;
   logic                frame_q;

   logic                period_end;
   logic                cfg_ready;
   logic                capture;
   logic                apply;
   logic                mode_change;

   mode_e               src_mode;
   logic [PH_W-1:0]     src_phase;
   logic [IDX_W-1:0]    src_idx;
   logic [PWM_BITS-1:0] breathe_duty;

   assign period_end = &pwm_ctr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cfg_state_q <= CFG_IDLE;
      end else begin
         cfg_state_q <= cfg_state_d;
      end
   end

   always_comb begin
      cfg_state_d = cfg_state_q;
      case (cfg_state_q)
         CFG_IDLE:    if (cfg_valid_i) cfg_state_d = CFG_PENDING;
         CFG_PENDING: if (period_end)  cfg_state_d = CFG_IDLE;
         default:     cfg_state_d = CFG_IDLE;
      endcase
   end

   // A config captured on a period_end edge is still PENDING only afterwards,
   // so it naturally waits for the following boundary.
   always_comb begin
      cfg_ready   = (cfg_state_q == CFG_IDLE);
      capture     = cfg_ready && cfg_valid_i;
      apply       = (cfg_state_q == CFG_PENDING) && period_end;
      mode_change = apply && (pend_mode_q != mode_q);
   end

   always_comb begin
      pend_mode_d  = pend_mode_q;
      pend_speed_d = pend_speed_q;
      if (capture) begin
         pend_mode_d  = mode_e'(cfg_mode_i);
         pend_speed_d = cfg_speed_i;
      end
   end

   always_comb begin
      pwm_ctr_d   = pwm_ctr_q + PWM_BITS'(1);
      div_ctr_d   = div_ctr_q;
      phase_d     = phase_q;
      chase_idx_d = chase_idx_q;
      mode_d      = mode_q;
      speed_d     = speed_q;
      if (apply) begin
         mode_d    = pend_mode_q;
         speed_d   = pend_speed_q;
         div_ctr_d = '0;
         if (mode_change) begin
            phase_d     = '0;
            chase_idx_d = '0;
         end
      end else if (period_end) begin
         if (div_ctr_q == speed_q) begin
            div_ctr_d   = '0;
            phase_d     = phase_q + PH_W'(1);
            chase_idx_d = (chase_idx_q == IDX_W'(NUM_LEDS - 1)) ? '0 : chase_idx_q + IDX_W'(1);
         end else begin
            div_ctr_d = div_ctr_q + DIV_BITS'(1);
         end
      end
   end

   // Duties are derived from the pre-step state, or from a fresh start when the mode switches.
   always_comb begin
      src_mode  = mode_q;
      src_phase = phase_q;
      src_idx   = chase_idx_q;
      if (mode_change) begin
         src_mode  = pend_mode_q;
         src_phase = '0;
         src_idx   = '0;
      end
      breathe_duty = PWM_BITS'(tri_wave(TRI_MAX_W'(src_phase), PWM_BITS));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pwm_ctr_q    <= '0;
         div_ctr_q    <= '0;
         phase_q      <= '0;
         chase_idx_q  <= '0;
         mode_q       <= MODE_SWEEP;
         speed_q      <= DIV_BITS'(DEFAULT_SPEED);
         pend_mode_q  <= MODE_OFF;
         pend_speed_q <= '0;
         frame_q      <= 1'b0;
      end else begin
         pwm_ctr_q    <= pwm_ctr_d;
         div_ctr_q    <= div_ctr_d;
         phase_q      <= phase_d;
         chase_idx_q  <= chase_idx_d;
         mode_q       <= mode_d;
         speed_q      <= speed_d;
         pend_mode_q  <= pend_mode_d;
         pend_speed_q <= pend_speed_d;
         frame_q      <= period_end;
      end
   end

   for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
      localparam logic [PH_W-1:0] CH_OFS = PH_W'(g * OFFSET);

      logic [PH_W-1:0]     sweep_ph;
      logic [PWM_BITS-1:0] duty_next;

      always_comb begin
         sweep_ph = src_phase + CH_OFS;
         case (src_mode)
            MODE_OFF:     duty_next = '0;
            MODE_SWEEP:   duty_next = PWM_BITS'(tri_wave(TRI_MAX_W'(sweep_ph), PWM_BITS));
            MODE_BREATHE: duty_next = breathe_duty;
            MODE_CHASE:   duty_next = (src_idx == IDX_W'(g)) ? '1 : '0;
            default:      duty_next = '0;
         endcase
      end

      pwm_channel #(
         .PWM_BITS (PWM_BITS)
      ) u_ch (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .load_i    (period_end),
         .duty_i    (duty_next),
         .pwm_ctr_i (pwm_ctr_q),
         .led_o     (led_o[g])
      );
   end

   assign cfg_ready_o = cfg_ready;
   assign frame_o     = frame_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench: stimulus pushes expected per-period high-cycle counts,
// a frame-driven monitor measures each PWM period and compares.
module tb_led_pattern_gen;
   import led_pkg::*;

   localparam int NL = 4;
   localparam int PB = 4;
   localparam int DB = 16;

   typedef struct {
      int          epoch;
      int          frame;
      logic [31:0] counts;
   } expect_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset;
   logic [1:0]    cfgMode;
   logic [DB-1:0] cfgSpeed;
   logic          cfgValid;
   logic          cfgReady;
   logic [NL-1:0] led;
   logic          frame;

   logic          resetBig;
   logic [1:0]    bigCfgMode  = 2'd0;
   logic [15:0]   bigCfgSpeed = 16'd0;
   logic          bigCfgValid = 1'b0;
   logic          bigReady;
   logic [7:0]    bigLed;
   logic          bigFrame;
   logic          bigDone = 1'b0;

   int            checks = 0;
   int            errors = 0;
   int            epoch = 0;
   int            frameIdx = 0;
   expect_t       expQ[$];

   led_pattern_gen #(
      .NUM_LEDS (NL), .PWM_BITS (PB), .DIV_BITS (DB), .DEFAULT_SPEED (0)
   ) dut (
      .clk_i (clock), .rst_i (reset),
      .cfg_mode_i (cfgMode), .cfg_speed_i (cfgSpeed), .cfg_valid_i (cfgValid),
      .cfg_ready_o (cfgReady), .led_o (led), .frame_o (frame)
   );

   led_pattern_gen dutBig (
      .clk_i (clock), .rst_i (resetBig),
      .cfg_mode_i (bigCfgMode), .cfg_speed_i (bigCfgSpeed), .cfg_valid_i (bigCfgValid),
      .cfg_ready_o (bigReady), .led_o (bigLed), .frame_o (bigFrame)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   // Inputs change and are read 1 time unit after the falling edge.
   task automatic tick();
      @(negedge clock);
      if (!reset && frame) frameIdx++;
      #1;
   endtask

   task automatic waitFrame(input int target);
      int budget;
      budget = 400;
      while (frameIdx < target && budget > 0) begin
         tick();
         budget--;
      end
      if (frameIdx != target) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_frame: reached frame %0d, required %0d", frameIdx, target);
      end
   endtask

   task automatic applyStimulus(input mode_e m, input int speed);
      cfgMode  = m;
      cfgSpeed = DB'(speed);
      cfgValid = 1'b1;
      tick();
      cfgValid = 1'b0;
   endtask

   task automatic pushExpect(input int f, input int c0, input int c1, input int c2, input int c3);
      expect_t e;
      e.epoch  = epoch;
      e.frame  = f;
      e.counts = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
      expQ.push_back(e);
   endtask

   // Monitor: each frame pulse closes the previous period window and opens a new one.
   initial begin
      int          monEpoch;
      int          monFrame;
      logic        monActive;
      logic        resetSeen;
      logic [31:0] acc;
      expect_t     head;
      monEpoch  = 0;
      monFrame  = 0;
      monActive = 1'b0;
      resetSeen = 1'b0;
      acc       = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            if (!resetSeen) monEpoch++;
            resetSeen = 1'b1;
            monFrame  = 0;
            monActive = 1'b0;
         end else begin
            resetSeen = 1'b0;
            if (frame) begin
               if (monActive) begin
                  while (expQ.size() > 0 && (expQ[0].epoch < monEpoch ||
                         (expQ[0].epoch == monEpoch && expQ[0].frame < monFrame))) begin
                     head = expQ.pop_front();
                     checks++;
                     errors++;
                     $display("[TB] FAIL e%0d_f%0d: window never observed, required 0x%0h",
                              head.epoch, head.frame, head.counts);
                  end
                  if (expQ.size() > 0 && expQ[0].epoch == monEpoch && expQ[0].frame == monFrame) begin
                     head = expQ.pop_front();
                     checkOutput($sformatf("counts_e%0d_f%0d", monEpoch, monFrame), acc, head.counts);
                  end
               end
               monFrame++;
               monActive = 1'b1;
               acc       = '0;
            end
            if (monActive) begin
               for (int i = 0; i < NL; i++) acc[i*8 +: 8] += 8'(led[i]);
            end
         end
      end
   end

   // Default-parameter instance: phase must hold for 256 periods of 256 clocks.
   initial begin
      int f;
      int c0;
      int c4;
      int cyc;
      f = 0; c0 = 0; c4 = 0; cyc = 0;
      resetBig = 1'b1;
      repeat (2) @(negedge clock);
      #1 resetBig = 1'b0;
      while (f < 258 && cyc < 70000) begin
         @(negedge clock);
         cyc++;
         if (bigFrame) begin
            if (f == 1 || f == 256 || f == 257) begin
               checkOutput($sformatf("big_f%0d_led0", f), c0, (f == 257) ? 1 : 0);
               checkOutput($sformatf("big_f%0d_led4", f), c4, (f == 257) ? 254 : 255);
            end
            f++;
            c0 = 0;
            c4 = 0;
         end
         if (f > 0) begin
            c0 += int'(bigLed[0]);
            c4 += int'(bigLed[4]);
         end
      end
      if (f < 258) begin
         checks++;
         errors++;
         $display("[TB] FAIL big_timeout: reached frame %0d, required 258", f);
      end
      bigDone = 1'b1;
   end

   initial begin
      logic [NL-1:0] ledSeen;
      expect_t       left;
      reset    = 1'b1;
      cfgValid = 1'b0;
      cfgMode  = 2'd0;
      cfgSpeed = '0;
      epoch    = 1;
      frameIdx = 0;
      repeat (3) tick();
      checkOutput("reset_led", 32'(led), 0);
      checkOutput("reset_ready", 32'(cfgReady), 1);
      reset = 1'b0;

      $display("[TB] sweep from reset");
      pushExpect(1, 0, 8, 15, 7);
      pushExpect(2, 1, 9, 14, 6);
      ledSeen = '0;
      for (int c = 0; c < 15; c++) begin
         tick();
         ledSeen |= led;
      end
      checkOutput("period1_dark", 32'(ledSeen), 0);

      $display("[TB] switch to breathe");
      waitFrame(3);
      pushExpect(3, 2, 10, 13, 5);
      // Apply frame and the first stepped frame both show phase 0.
      pushExpect(4, 0, 0, 0, 0);
      pushExpect(5, 0, 0, 0, 0);
      pushExpect(6, 1, 1, 1, 1);
      pushExpect(7, 2, 2, 2, 2);
      pushExpect(8, 3, 3, 3, 3);
      checkOutput("ready_before_capture", 32'(cfgReady), 1);
      applyStimulus(MODE_BREATHE, 0);
      checkOutput("ready_low_after_capture", 32'(cfgReady), 0);
      repeat (14) tick();
      checkOutput("ready_low_apply_cycle", 32'(cfgReady), 0);
      tick();
      checkOutput("ready_back_after_apply", 32'(cfgReady), 1);
      checkOutput("frame_pulse", 32'(frame), 1);

      $display("[TB] chase captured on a period boundary");
      waitFrame(8);
      pushExpect(9, 4, 4, 4, 4);
      pushExpect(10, 15, 0, 0, 0);
      pushExpect(11, 15, 0, 0, 0);
      pushExpect(12, 15, 0, 0, 0);
      pushExpect(13, 0, 15, 0, 0);
      pushExpect(14, 0, 15, 0, 0);
      pushExpect(15, 0, 0, 15, 0);
      pushExpect(16, 0, 0, 15, 0);
      pushExpect(17, 0, 0, 0, 15);
      pushExpect(18, 0, 0, 0, 15);
      pushExpect(19, 15, 0, 0, 0);
      repeat (15) tick();
      applyStimulus(MODE_CHASE, 1);
      checkOutput("ready_low_after_edge_capture", 32'(cfgReady), 0);
      repeat (3) tick();
      applyStimulus(MODE_OFF, 0);
      checkOutput("ready_still_low", 32'(cfgReady), 0);
      waitFrame(10);
      checkOutput("ready_after_chase_apply", 32'(cfgReady), 1);

      $display("[TB] reset with a pending config");
      waitFrame(20);
      repeat (4) tick();
      applyStimulus(MODE_BREATHE, 3);
      tick();
      checkOutput("ready_low_pending", 32'(cfgReady), 0);
      reset    = 1'b1;
      epoch++;
      frameIdx = 0;
      tick();
      checkOutput("midreset_led", 32'(led), 0);
      checkOutput("midreset_ready", 32'(cfgReady), 1);
      checkOutput("midreset_frame", 32'(frame), 0);
      pushExpect(1, 0, 8, 15, 7);
      pushExpect(2, 1, 9, 14, 6);
      reset = 1'b0;
      waitFrame(3);

      wait (bigDone);
      while (expQ.size() > 0) begin
         left = expQ.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL e%0d_f%0d: never compared, required 0x%0h", left.epoch, left.frame, left.counts);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
